// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the burst memory arbiter
// Contents: burst geometry defaults, line/beat typedefs, arbiter state enum,
// and a line-alignment helper for burst addresses.
package mem_pkg;

  localparam int BEATS_DEF  = 4;
  localparam int BEAT_W_DEF = 64;
  localparam int LINE_W     = BEATS_DEF * BEAT_W_DEF;

  typedef logic [BEAT_W_DEF-1:0] beat_t;
  typedef logic [LINE_W-1:0]     line_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Clear the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int ofs_bits);
    return addr & ~((32'd1 << ofs_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one line request into a memory burst
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   read_i, write_i          line request from the selected cache port
//   address_i, wdata_i       request address and write line
//   rdata_o, resp_o          assembled line register, one-cycle completion pulse
//   idle_o                   high while able to accept a new request
//   mem_read_o, mem_write_o  burst request to memory
//   mem_address_o            line-aligned burst address
//   mem_wdata_o              current write beat
//   mem_rdata_i, mem_resp_i  current read beat, per-beat handshake
module cacheline_adaptor
  import mem_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_i,
  input  logic                      write_i,
  input  logic [31:0]               address_i,
  input  logic [BEATS*BEAT_W-1:0]   wdata_i,
  output logic [BEATS*BEAT_W-1:0]   rdata_o,
  output logic                      resp_o,
  output logic                      idle_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic [31:0]               mem_address_o,
  output logic [BEAT_W-1:0]         mem_wdata_o,
  input  logic [BEAT_W-1:0]         mem_rdata_i,
  input  logic                      mem_resp_i
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS_W = $clog2(BEATS * BEAT_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BEATS*BEAT_W-1:0]   line_q;
  logic [31:0]               addr_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic                      resp_q;

  // The line register doubles as write source and read assembly buffer;
  // counter wraps to zero naturally on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      resp_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          // Write wins over a simultaneous read on the same port.
          if (write_i) begin
            line_q      <= wdata_i;
            addr_q      <= line_align(address_i, OFS_W);
            mem_write_q <= 1'b1;
            state_q     <= ST_WRITE;
          end else if (read_i) begin
            addr_q     <= line_align(address_i, OFS_W);
            mem_read_q <= 1'b1;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_resp_i) begin
            line_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= mem_rdata_i;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              mem_read_q <= 1'b0;
              resp_q     <= 1'b1;
              state_q    <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_resp_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              mem_write_q <= 1'b0;
              resp_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          resp_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle_o        = (state_q == ST_IDLE);
  assign rdata_o       = line_q;
  assign resp_o        = resp_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = addr_q;
  // Only present a beat while writing so the bus reads as zero otherwise.
  assign mem_wdata_o   = mem_write_q ? line_q[int'(cnt_q)*BEAT_W +: BEAT_W] : '0;

endmodule

// File: rtl/mem_burst_arbiter.sv
// rtl/mem_burst_arbiter.sv - round-robin arbiter of I/D cache lines onto one burst memory
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   i_read, i_write, i_address, i_wdata      instruction-cache line request
//   i_rdata, i_resp                          instruction-cache read line, completion pulse
//   d_read, d_write, d_address, d_wdata      data-cache line request
//   d_rdata, d_resp                          data-cache read line, completion pulse
//   mem_read, mem_write, mem_address         burst request to memory
//   mem_wdata, mem_rdata, mem_resp           per-beat data and handshake
module mem_burst_arbiter
  import mem_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_read,
  input  logic                      i_write,
  input  logic [31:0]               i_address,
  input  logic [BEATS*BEAT_W-1:0]   i_wdata,
  output logic [BEATS*BEAT_W-1:0]   i_rdata,
  output logic                      i_resp,
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [31:0]               d_address,
  input  logic [BEATS*BEAT_W-1:0]   d_wdata,
  output logic [BEATS*BEAT_W-1:0]   d_rdata,
  output logic                      d_resp,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_address,
  output logic [BEAT_W-1:0]         mem_wdata,
  input  logic [BEAT_W-1:0]         mem_rdata,
  input  logic                      mem_resp
);

  logic                    grant_q;       // 0 = I, 1 = D
  logic                    grant_d;
  logic                    last_grant_q;
  logic                    sel;
  logic                    i_req;
  logic                    d_req;
  logic                    idle;
  logic                    resp;
  logic                    a_read;
  logic                    a_write;
  logic [31:0]             a_address;
  logic [BEATS*BEAT_W-1:0] a_wdata;
  logic [BEATS*BEAT_W-1:0] line;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  always_comb begin
    grant_d = grant_q;
    if (i_req && d_req) begin
      grant_d = ~last_grant_q;
    end else if (i_req) begin
      grant_d = 1'b0;
    end else if (d_req) begin
      grant_d = 1'b1;
    end
  end

  // While idle the mux follows the live decision so the adaptor can latch
  // the winner in the grant cycle; afterwards it is frozen for the burst.
  assign sel = idle ? grant_d : grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (idle && (i_req || d_req)) begin
        grant_q <= grant_d;
      end
      if (resp) begin
        last_grant_q <= grant_q;
      end
    end
  end

  assign a_read    = sel ? d_read    : i_read;
  assign a_write   = sel ? d_write   : i_write;
  assign a_address = sel ? d_address : i_address;
  assign a_wdata   = sel ? d_wdata   : i_wdata;

  cacheline_adaptor #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_adaptor (
    .clk           (clk),
    .rst           (rst),
    .read_i        (a_read),
    .write_i       (a_write),
    .address_i     (a_address),
    .wdata_i       (a_wdata),
    .rdata_o       (line),
    .resp_o        (resp),
    .idle_o        (idle),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .mem_address_o (mem_address),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_resp_i    (mem_resp)
  );

  assign i_resp  = resp & ~grant_q;
  assign d_resp  = resp &  grant_q;
  assign i_rdata = line;
  assign d_rdata = line;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb/tb_mem_burst_arbiter.sv - scoreboard bench for mem_burst_arbiter with a latency memory model
module tb_mem_burst_arbiter;
  import mem_pkg::*;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 64;
  localparam int RESP_LAT = 50;
  localparam int PAGE_LAT = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, i_write, d_read, d_write;
  logic [31:0] i_address, d_address;
  line_t       i_wdata, d_wdata, i_rdata, d_rdata;
  logic        i_resp, d_resp;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  beat_t       mem_wdata;
  beat_t       mem_rdata = '0;
  logic        mem_resp = 1'b0;

  always #5 clk = ~clk;

  mem_burst_arbiter #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic line_t pat(input logic [31:0] a);
    if (a == 32'h0000_1220)
      return {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    return {{2{a ^ 32'h0F0F_0F0F}}, {2{a + 32'h1357_9BDF}}, {2{~a}}, {2{a}}};
  endfunction

  typedef struct {
    bit    port;
    bit    has_data;
    line_t data;
  } exp_t;

  exp_t  exp_q[$];
  beat_t wb_q[$];
  int    stray_req = 0;

  task automatic push_exp(input bit port, input bit has_data, input line_t data);
    exp_t e;
    e.port = port;
    e.has_data = has_data;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_wbeats(input line_t l);
    for (int b = 0; b < BEATS; b++) wb_q.push_back(l[b*BEAT_W +: BEAT_W]);
  endtask

  // Memory model with first-beat latency, page penalty, and protocol monitor.
  line_t       mem_store [bit [31:0]];
  bit          m_busy = 1'b0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_wait = 0;
  int          beats_done = 0;
  line_t       m_line = '0;
  logic [23:0] last_page = '1;
  int          stray_done = 0;
  logic        prev_mr = 1'b0, prev_mw = 1'b0, prev_final = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (mem_read || mem_write) begin
        check("rw_excl", 256'(mem_read & mem_write), 256'(0));
        check("req_held", 256'(i_read | i_write | d_read | d_write), 256'(1));
      end
      if ((prev_mr || prev_mw) && !prev_final) begin
        check("rd_hold", 256'(mem_read), 256'(prev_mr));
        check("wr_hold", 256'(mem_write), 256'(prev_mw));
        check("addr_hold", 256'(mem_address), 256'(prev_addr));
      end
    end
    prev_rst   = rst;
    prev_mr    = mem_read;
    prev_mw    = mem_write;
    prev_addr  = mem_address;
    prev_final = 1'b0;
    mem_resp   = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_wait > 0) begin
        m_wait--;
      end else begin
        mem_resp = 1'b1;
        if (m_wr) begin
          check("wr_no_rd", 256'(mem_read), 256'(0));
          check("wbeat_avail", 256'(wb_q.size() > 0), 256'(1));
          if (wb_q.size() > 0) check("wbeat", 256'(mem_wdata), 256'(wb_q.pop_front()));
          m_line[beats_done*BEAT_W +: BEAT_W] = mem_wdata;
        end else begin
          mem_rdata = m_line[beats_done*BEAT_W +: BEAT_W];
        end
        beats_done++;
        if (beats_done == BEATS) begin
          m_busy = 1'b0;
          prev_final = 1'b1;
          if (m_wr) mem_store[m_addr] = m_line;
        end
      end
    end else if (mem_read || mem_write) begin
      m_busy     = 1'b1;
      m_wr       = mem_write;
      m_addr     = mem_address;
      beats_done = 0;
      m_line     = mem_store.exists(mem_address) ? mem_store[mem_address] : pat(mem_address);
      m_wait     = RESP_LAT - 1 + ((mem_address[31:8] != last_page) ? PAGE_LAT : 0);
      last_page  = mem_address[31:8];
    end else if (stray_req != stray_done) begin
      mem_resp  = 1'b1;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      stray_done++;
    end
  end

  task automatic wait_start(input string tag, input logic [31:0] addr, input bit wr);
    int cyc = 0;
    while (!(mem_read || mem_write) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 256'(cyc), 256'(1));
    check({tag, "_addr"}, 256'(mem_address), 256'(addr));
    check({tag, "_kind"}, 256'({mem_write, mem_read}), 256'({wr, ~wr}));
  endtask

  task automatic wait_resps(input string tag, input int n);
    int   got = 0;
    int   cyc = 0;
    logic pi = 1'b0, pd = 1'b0;
    exp_t e;
    bit   port;
    while (got < n && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (pi) check({tag, "_i_pulse"}, 256'(i_resp), 256'(0));
      if (pd) check({tag, "_d_pulse"}, 256'(d_resp), 256'(0));
      pi = i_resp;
      pd = d_resp;
      if (i_resp || d_resp) begin
        check({tag, "_resp_excl"}, 256'(i_resp & d_resp), 256'(0));
        check({tag, "_expected"}, 256'(exp_q.size() > 0), 256'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          port = d_resp;
          check({tag, "_order"}, 256'(port), 256'(e.port));
          if (e.has_data) check({tag, "_rdata"}, port ? d_rdata : i_rdata, e.data);
        end
        if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
        else begin i_read = 1'b0; i_write = 1'b0; end
        got++;
      end
    end
    check({tag, "_count"}, 256'(got), 256'(n));
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 256'({i_resp, d_resp}), 256'(0));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem"}, 256'({mem_read, mem_write, mem_address, mem_wdata}), 256'(0));
    check({tag, "_resp"}, 256'({i_resp, d_resp}), 256'(0));
    check({tag, "_rdata"}, i_rdata | d_rdata, 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  line_t wline;
  line_t wline5;

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_write = 1'b0; i_address = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Data-cache read of an unaligned address.
    d_address = 32'h0000_1234;
    d_read = 1'b1;
    push_exp(1'b1, 1'b1, pat(32'h0000_1220));
    wait_start("dread", 32'h0000_1220, 1'b0);
    wait_resps("dread", 1);

    // Two rounds of simultaneous requests: I, D, I, D.
    for (int r = 0; r < 2; r++) begin
      i_address = 32'h100 + 32'(r) * 32'h200;
      d_address = 32'h200 + 32'(r) * 32'h200;
      push_exp(1'b0, 1'b1, pat(i_address));
      push_exp(1'b1, 1'b1, pat(d_address));
      i_read = 1'b1;
      d_read = 1'b1;
      wait_resps("rr", 2);
    end

    // Instruction-cache write, then read the line back.
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    i_address = 32'h0000_0040;
    i_wdata = wline;
    push_wbeats(wline);
    push_exp(1'b0, 1'b0, '0);
    i_write = 1'b1;
    wait_start("iwrite", 32'h0000_0040, 1'b1);
    wait_resps("iwrite", 1);
    check("iwrite_wb_drained", 256'(wb_q.size()), 256'(0));
    push_exp(1'b0, 1'b1, wline);
    i_read = 1'b1;
    wait_resps("iread_back", 1);

    // Reset after the second read beat, then a normal read.
    d_address = 32'h0000_0500;
    d_read = 1'b1;
    wait_start("rst_mid", 32'h0000_0500, 1'b0);
    for (int c = 0; c < 500 && beats_done != 2; c++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_beats", 256'(beats_done), 256'(2));
    rst = 1'b1;
    d_read = 1'b0;
    @(posedge clk); #1;
    check_quiet("rst_mid");
    rst = 1'b0;
    @(posedge clk); #1;
    d_address = 32'h0000_0600;
    d_read = 1'b1;
    push_exp(1'b1, 1'b1, pat(32'h0000_0600));
    wait_start("after_rst", 32'h0000_0600, 1'b0);
    wait_resps("after_rst", 1);

    // Stray memory response while idle, then read+write on one port.
    stray_req++;
    repeat (3) @(posedge clk);
    #1;
    check("stray_sent", 256'(stray_done), 256'(stray_req));
    check("stray_idle", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(0));
    wline5 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5A5A_A5A5_5A5A_A5A5, 64'hC3C3_3C3C_C3C3_3C3C};
    d_address = 32'h0000_0713;
    d_wdata = wline5;
    push_wbeats(wline5);
    push_exp(1'b1, 1'b0, '0);
    d_read = 1'b1;
    d_write = 1'b1;
    wait_start("rw_same", 32'h0000_0700, 1'b1);
    wait_resps("rw_same", 1);
    check("rw_same_wb_drained", 256'(wb_q.size()), 256'(0));
    push_exp(1'b1, 1'b1, wline5);
    d_read = 1'b1;
    wait_resps("dread_back", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_arbiter.md
MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
REQ-001 Parameter BEATS, default 4, burst beats per cache line.
REQ-002 Parameter BEAT_W, default 64, bits per beat; line width is BEATS*BEAT_W (256).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_read/i_write  input  1 each  instruction-cache request, held high until i_resp.
REQ-006 i_address  input  32  instruction-cache line address.
REQ-007 i_wdata  input  256  instruction-cache write line; i_rdata  output  256  read line.
REQ-008 i_resp  output  1  instruction-cache completion pulse.
REQ-009 d_read, d_write, d_address, d_wdata, d_rdata, d_resp: same widths and meanings as REQ-005..008, for the data cache.
REQ-010 mem_read/mem_write  output  1 each  burst request to the parameterized memory model.
REQ-011 mem_address  output  32  burst address, always {addr[31:5],5'b0}.
REQ-012 mem_wdata  output  64  current write beat; mem_rdata  input  64  current read beat.
REQ-013 mem_resp  input  1  one pulse per beat transferred.

Function
REQ-014 States: IDLE, READ, WRITE, DONE; 2-bit beat counter; 1-bit grant (0=I, 1=D); 1-bit last_grant.
REQ-015 IDLE: with exactly one port requesting, grant that port; with both requesting, grant the port opposite last_grant (round-robin).
REQ-016 On grant, latch the address and the write line; go to WRITE if that port's write is high (write wins over a simultaneous read on the same port), otherwise READ.
REQ-017 READ: mem_read=1; each mem_resp stores mem_rdata into line slice [64*cnt +: 64] and increments cnt; on the 4th beat go to DONE.
REQ-018 WRITE: mem_write=1; mem_wdata = latched line slice [64*cnt +: 64]; each mem_resp increments cnt; on the 4th beat go to DONE.
REQ-019 mem_read/mem_write remain high and mem_address remains stable from the first request cycle through the cycle of the final mem_resp; they are never high together.
REQ-020 DONE: assert the granted port's resp for exactly one cycle, with rdata holding the assembled line; update last_grant; return to IDLE.
REQ-021 The first memory request begins the cycle after grant; resp reaches the cache one cycle after the final mem_resp.
REQ-022 The non-granted port sees resp=0 and its request is held off; rdata of both ports is driven from one shared line register.
REQ-023 mem_resp outside READ/WRITE is ignored; beat counter wraps 3->0 only at burst end.
REQ-024 A request dropped mid-burst does not abort the burst (a protocol violation, flagged by a bench assertion).

Reset
REQ-025 rst forces IDLE, cnt=0, last_grant=1 (I wins the first tie), line register=0, and all outputs to 0 in the next cycle, including mid-burst.
REQ-026 After a mid-burst reset, the memory model is reset in the same cycle; no memory-side recovery is required.

Structure
REQ-027 Shared package mem_pkg holds the state enum, BEATS/BEAT_W defaults, and the line_t (256) / beat_t (64) typedefs.
REQ-028 Natural sub-module: cacheline_adaptor (one-port line to burst conversion, covering REQ-017..019), instantiated once behind the arbitration mux.
REQ-029 The arbiter replaces separate magic memory ports when the parameterized memory model is selected.

Verification
REQ-030 d_read, addr 0x0000_1234, memory beats 0x11..,0x22..,0x33..,0x44.. -> mem_address 0x0000_1220; d_rdata={0x44..,0x33..,0x22..,0x11..}; d_resp one cycle.
REQ-031 i_write, line 0xDDDD..CCCC..BBBB..AAAA.. -> mem_wdata beats in order AAAA, BBBB, CCCC, DDDD; i_resp once; mem_read stays 0.
REQ-032 i_read and d_read raised together twice back-to-back -> order I, D, I, D; each resp only after the previous burst completes.
REQ-033 rst asserted after beat 2 of a read -> next cycle all outputs 0, state IDLE; a fresh d_read then completes normally.
REQ-034 Stray mem_resp in IDLE, plus d_read and d_write held simultaneously -> stray pulse ignored; write burst is issued.
REQ-035 Bench asserts REQ-019 every cycle against ParamMemory with 50-cycle response and 25-cycle page latency.
